// File: rtl/adbg_wb_burst_ctrl.sv
// Burst sequencer between the debug command decoder and the WishBone BIU strobe/ready port.
// Issues one BIU access per word, stepping the byte address by the word size (TCK domain only).
//
// state   | meaning
// IDLE    | waiting for a burst command
// FETCH   | write burst: waiting for the next write word
// ISSUE   | waiting for BIU ready; strobe is raised in the ready cycle
// WAIT    | access in flight; rdy ignored in the first cycle
// DELIVER | read word held until the consumer takes it
// DONE    | one-cycle completion pulse
module adbg_wb_burst_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             tck_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_rd_wrn_i,
    input  logic [31:0]      cmd_addr_i,
    input  logic [2:0]       cmd_size_i,
    input  logic [CNT_W-1:0] cmd_count_i,
    input  logic             abort_i,
    input  logic [31:0]      wdata_i,
    input  logic             wdata_valid_i,
    output logic             wdata_ready_o,
    output logic [31:0]      rdata_o,
    output logic             rdata_valid_o,
    input  logic             rdata_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [31:0]      err_addr_o,
    output logic [CNT_W-1:0] words_done_o,
    output logic             biu_strobe_o,
    output logic             biu_rd_wrn_o,
    output logic [31:0]      biu_addr_o,
    output logic [31:0]      biu_data_o,
    output logic [2:0]       biu_size_o,
    input  logic             biu_rdy_i,
    input  logic             biu_err_i,
    input  logic [31:0]      biu_data_i
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        ISSUE   = 3'd2,
        WAIT    = 3'd3,
        DELIVER = 3'd4,
        DONE    = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [2:0]       size_q, size_d;
    logic             rd_wrn_q, rd_wrn_d;
    logic [31:0]      data_q, data_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] words_done_q, words_done_d;
    logic             err_q, err_d;
    logic [31:0]      err_addr_q, err_addr_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rdata_valid_q, rdata_valid_d;
    logic             abort_q, abort_d;
    logic             wait_first_q, wait_first_d;

    logic             abort_now;
    logic             advance;
    logic [2:0]       size_norm;
    logic [31:0]      addr_next;
    logic             last_word;
    state_e           adv_state;

    // Illegal sizes collapse to a 4-byte word.
    assign size_norm = (cmd_size_i == 3'h1 || cmd_size_i == 3'h2) ? cmd_size_i : 3'h4;
    assign abort_now = abort_q | abort_i;
    assign addr_next = addr_q + {29'd0, size_q};
    assign last_word = (remaining_q == CNT_W'(1));
    assign adv_state = (last_word || abort_now) ? DONE : (rd_wrn_q ? ISSUE : FETCH);

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        size_d        = size_q;
        rd_wrn_d      = rd_wrn_q;
        data_d        = data_q;
        remaining_d   = remaining_q;
        words_done_d  = words_done_q;
        err_d         = err_q;
        err_addr_d    = err_addr_q;
        rdata_d       = rdata_q;
        rdata_valid_d = rdata_valid_q;
        abort_d       = (state_q != IDLE) ? abort_now : abort_q;
        wait_first_d  = wait_first_q;
        advance       = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    addr_d       = cmd_addr_i;
                    size_d       = size_norm;
                    rd_wrn_d     = cmd_rd_wrn_i;
                    remaining_d  = cmd_count_i;
                    err_d        = 1'b0;
                    err_addr_d   = '0;
                    words_done_d = '0;
                    abort_d      = 1'b0;
                    if (cmd_count_i == '0) begin
                        state_d = DONE;
                    end else if (cmd_rd_wrn_i) begin
                        state_d = ISSUE;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                if (!abort_q && wdata_valid_i) begin
                    data_d  = wdata_i;
                    state_d = ISSUE;
                end else if (abort_now) begin
                    state_d = DONE;
                end
            end
            ISSUE: begin
                if (biu_rdy_i) begin
                    state_d      = WAIT;
                    wait_first_d = 1'b1;
                end
            end
            WAIT: begin
                // The BIU still shows the previous rdy for one cycle after the strobe.
                if (wait_first_q) begin
                    wait_first_d = 1'b0;
                end else if (biu_rdy_i) begin
                    if (biu_err_i && !err_q) begin
                        err_d      = 1'b1;
                        err_addr_d = addr_q;
                    end
                    words_done_d = words_done_q + CNT_W'(1);
                    if (rd_wrn_q) begin
                        rdata_d       = biu_data_i;
                        rdata_valid_d = 1'b1;
                        state_d       = DELIVER;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            DELIVER: begin
                if (rdata_ready_i) begin
                    rdata_valid_d = 1'b0;
                    advance       = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (advance) begin
            addr_d      = addr_next;
            remaining_d = remaining_q - CNT_W'(1);
            state_d     = adv_state;
        end
    end

    always_ff @(posedge tck_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            size_q        <= 3'h4;
            rd_wrn_q      <= 1'b1;
            data_q        <= '0;
            remaining_q   <= '0;
            words_done_q  <= '0;
            err_q         <= 1'b0;
            err_addr_q    <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            abort_q       <= 1'b0;
            wait_first_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            size_q        <= size_d;
            rd_wrn_q      <= rd_wrn_d;
            data_q        <= data_d;
            remaining_q   <= remaining_d;
            words_done_q  <= words_done_d;
            err_q         <= err_d;
            err_addr_q    <= err_addr_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            abort_q       <= abort_d;
            wait_first_q  <= wait_first_d;
        end
    end

    assign cmd_ready_o   = (state_q == IDLE);
    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == DONE);
    assign wdata_ready_o = (state_q == FETCH) && !abort_q;
    assign biu_strobe_o  = (state_q == ISSUE) && biu_rdy_i;
    assign biu_rd_wrn_o  = rd_wrn_q;
    assign biu_addr_o    = addr_q;
    assign biu_data_o    = data_q;
    assign biu_size_o    = size_q;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rdata_valid_q;
    assign err_o         = err_q;
    assign err_addr_o    = err_addr_q;
    assign words_done_o  = words_done_q;

endmodule

// File: tb/tb_adbg_wb_burst_ctrl.sv
// Bench for adbg_wb_burst_ctrl: behavioural BIU, write-data source and read sink with random timing;
// expectations come from burst arithmetic (addr + i*size, first error index, word lists).
module tb_adbg_wb_burst_ctrl;
    localparam int CNT_W = 16;

    logic             tck = 1'b0;
    logic             rst;
    logic             cmd_valid, cmd_ready, cmd_rd_wrn;
    logic [31:0]      cmd_addr;
    logic [2:0]       cmd_size;
    logic [CNT_W-1:0] cmd_count;
    logic             abort;
    logic [31:0]      wdata;
    logic             wdata_valid, wdata_ready;
    logic [31:0]      rdata;
    logic             rdata_valid, rdata_ready;
    logic             busy, done, err;
    logic [31:0]      err_addr;
    logic [CNT_W-1:0] words_done;
    logic             biu_strobe, biu_rd_wrn;
    logic [31:0]      biu_addr, biu_wdata;
    logic [2:0]       biu_size;
    logic             biu_rdy, biu_err;
    logic [31:0]      biu_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int viol_cnt = 0;
    bit rd_hold = 1'b0;
    bit wr_throttle = 1'b0;

    logic [31:0] st_addr[$];
    logic [31:0] st_data[$];
    logic        st_rd[$];
    logic [2:0]  st_size[$];
    logic [31:0] resp_data[$];
    bit          resp_err[$];
    logic [31:0] wq[$];
    logic [31:0] got_rdata[$];

    adbg_wb_burst_ctrl #(.CNT_W(CNT_W)) dut (
        .tck_i(tck), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_rd_wrn_i(cmd_rd_wrn),
        .cmd_addr_i(cmd_addr), .cmd_size_i(cmd_size), .cmd_count_i(cmd_count),
        .abort_i(abort),
        .wdata_i(wdata), .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready),
        .rdata_o(rdata), .rdata_valid_o(rdata_valid), .rdata_ready_i(rdata_ready),
        .busy_o(busy), .done_o(done), .err_o(err), .err_addr_o(err_addr),
        .words_done_o(words_done),
        .biu_strobe_o(biu_strobe), .biu_rd_wrn_o(biu_rd_wrn), .biu_addr_o(biu_addr),
        .biu_data_o(biu_wdata), .biu_size_o(biu_size),
        .biu_rdy_i(biu_rdy), .biu_err_i(biu_err), .biu_data_i(biu_rdata)
    );

    always #5 tck = ~tck;

    always @(negedge tck) begin
        if (!rst) begin
            if (done) done_cnt++;
            if (biu_strobe && !biu_rdy) viol_cnt++;
            if (rdata_valid && rdata_ready) got_rdata.push_back(rdata);
        end
    end

    // Behavioural BIU: rdy stays high one cycle past the strobe, then random latency.
    int          b_lat, b_stall;
    logic [31:0] b_d;
    bit          b_e;
    initial begin
        biu_rdy = 1'b1; biu_err = 1'b0; biu_rdata = '0;
        forever begin
            @(negedge tck);
            if (!rst && biu_strobe) begin
                st_addr.push_back(biu_addr);
                st_data.push_back(biu_wdata);
                st_rd.push_back(biu_rd_wrn);
                st_size.push_back(biu_size);
                b_d = (resp_data.size() > 0) ? resp_data.pop_front() : $urandom;
                b_e = (resp_err.size() > 0) ? resp_err.pop_front() : 1'b0;
                b_lat = $urandom_range(0, 3);
                b_stall = $urandom_range(0, 2);
                @(posedge tck); #1;
                @(posedge tck); #1;
                if (b_lat > 0) begin
                    biu_rdy = 1'b0;
                    repeat (b_lat) @(posedge tck);
                    #1;
                end
                biu_rdy = 1'b1; biu_rdata = b_d; biu_err = b_e;
                @(posedge tck); #1;
                biu_err = 1'b0;
                if (b_stall > 0) begin
                    biu_rdy = 1'b0;
                    repeat (b_stall) @(posedge tck);
                    #1;
                    biu_rdy = 1'b1;
                end
            end
        end
    end

    bit w_ph = 1'b0;
    initial begin
        wdata_valid = 1'b0; wdata = '0;
        forever begin
            @(negedge tck);
            if (!rst && wdata_valid && wdata_ready && wq.size() > 0) void'(wq.pop_front());
            @(posedge tck); #1;
            w_ph = ~w_ph;
            if (wq.size() > 0 && (wr_throttle ? w_ph : ($urandom_range(0, 3) != 0))) begin
                wdata_valid = 1'b1; wdata = wq[0];
            end else begin
                wdata_valid = 1'b0; wdata = $urandom;
            end
        end
    end

    initial begin
        rdata_ready = 1'b0;
        forever begin
            @(posedge tck); #1;
            rdata_ready = rd_hold ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic start_cmd(input bit rd, input logic [31:0] a, input logic [2:0] sz,
                             input logic [CNT_W-1:0] cnt);
        st_addr.delete(); st_data.delete(); st_rd.delete(); st_size.delete();
        got_rdata.delete();
        @(posedge tck); #1;
        cmd_valid = 1'b1; cmd_rd_wrn = rd; cmd_addr = a; cmd_size = sz; cmd_count = cnt;
        @(posedge tck); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        int cyc;
        ok = 1'b0;
        cyc = 0;
        while (cyc < 3000 && !ok) begin
            @(negedge tck);
            if (done) ok = 1'b1;
            cyc++;
        end
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL done_timeout: done_o not seen in %0d cycles, required a pulse", cyc);
        end
    endtask

    task automatic clear_env();
        resp_data.delete(); resp_err.delete(); wq.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_rd_wrn = 1'b0; cmd_addr = '0; cmd_size = 3'h4;
        cmd_count = '0; abort = 1'b0;
        repeat (3) @(negedge tck);
        n_tests++;
        if ({cmd_ready, wdata_ready, rdata_valid, busy, done, err, biu_strobe, biu_rd_wrn} !== 8'b1000_0001) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, required 10000001",
                     {cmd_ready, wdata_ready, rdata_valid, busy, done, err, biu_strobe, biu_rd_wrn});
        end
        n_tests++;
        if ({err_addr, biu_addr, biu_wdata, rdata} !== 128'd0 || words_done !== '0) begin
            n_fail++;
            $display("FAIL reset_data: err_addr=%h biu_addr=%h biu_data=%h rdata=%h words=%0d, required all 0",
                     err_addr, biu_addr, biu_wdata, rdata, words_done);
        end
        n_tests++;
        if (biu_size !== 3'h4) begin
            n_fail++; $display("FAIL reset_size: got %h, required 4", biu_size);
        end
        @(posedge tck); #1;
        rst = 1'b0;
        @(negedge tck);
        n_tests++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset: ready=%b busy=%b, required 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_read_basic();
        bit ok;
        int d0;
        logic [31:0] exp_d[$];
        clear_env();
        exp_d = '{32'hA, 32'hB, 32'hC};
        resp_data = exp_d;
        resp_err = '{1'b0, 1'b0, 1'b0};
        d0 = done_cnt;
        start_cmd(1'b1, 32'h1000, 3'h4, 16'd3);
        wait_done(ok);
        @(negedge tck); @(negedge tck);
        n_tests++;
        if (st_addr.size() !== 3) begin
            n_fail++; $display("FAIL rd_strobes: got %0d, required 3", st_addr.size());
        end
        for (int i = 0; i < 3 && i < st_addr.size(); i++) begin
            n_tests++;
            if (st_addr[i] !== 32'h1000 + 32'(4 * i) || st_rd[i] !== 1'b1 || st_size[i] !== 3'h4) begin
                n_fail++;
                $display("FAIL rd_access%0d: addr=%h rd=%b size=%h, required %h 1 4",
                         i, st_addr[i], st_rd[i], st_size[i], 32'h1000 + 32'(4 * i));
            end
        end
        n_tests++;
        if (got_rdata !== exp_d) begin
            n_fail++; $display("FAIL rd_data: got %p, required %p", got_rdata, exp_d);
        end
        n_tests++;
        if (done_cnt - d0 !== 1 || words_done !== 16'd3 || err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_status: done=%0d words=%0d err=%b busy=%b, required 1 3 0 0",
                     done_cnt - d0, words_done, err, busy);
        end
    endtask

    task automatic test_write_throttled();
        bit ok;
        logic [31:0] words[$];
        clear_env();
        for (int i = 0; i < 4; i++) words.push_back($urandom);
        wq = words;
        wr_throttle = 1'b1;
        start_cmd(1'b0, 32'h3, 3'h1, 16'd4);
        wait_done(ok);
        @(negedge tck); @(negedge tck);
        wr_throttle = 1'b0;
        n_tests++;
        if (st_addr.size() !== 4) begin
            n_fail++; $display("FAIL wr_strobes: got %0d, required 4", st_addr.size());
        end
        for (int i = 0; i < 4 && i < st_addr.size(); i++) begin
            n_tests++;
            if (st_addr[i] !== 32'h3 + 32'(i) || st_data[i] !== words[i] ||
                st_rd[i] !== 1'b0 || st_size[i] !== 3'h1) begin
                n_fail++;
                $display("FAIL wr_access%0d: addr=%h data=%h rd=%b size=%h, required %h %h 0 1",
                         i, st_addr[i], st_data[i], st_rd[i], st_size[i], 32'h3 + 32'(i), words[i]);
            end
        end
        n_tests++;
        if (viol_cnt !== 0 || words_done !== 16'd4) begin
            n_fail++;
            $display("FAIL wr_status: strobe_without_rdy=%0d words=%0d, required 0 4", viol_cnt, words_done);
        end
    endtask

    task automatic test_read_backpressure();
        bit ok;
        bit seen;
        logic [31:0] exp_d[$];
        clear_env();
        exp_d = '{$urandom, $urandom};
        resp_data = exp_d;
        rd_hold = 1'b1;
        start_cmd(1'b1, 32'h80, 3'h2, 16'd2);
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge tck);
            if (rdata_valid) seen = 1'b1;
        end
        repeat (10) @(negedge tck);
        n_tests++;
        if (!seen || st_addr.size() !== 1 || rdata_valid !== 1'b1 || rdata !== exp_d[0]) begin
            n_fail++;
            $display("FAIL bp_hold: seen=%b strobes=%0d valid=%b rdata=%h, required 1 1 1 %h",
                     seen, st_addr.size(), rdata_valid, rdata, exp_d[0]);
        end
        rd_hold = 1'b0;
        wait_done(ok);
        @(negedge tck); @(negedge tck);
        n_tests++;
        if (got_rdata !== exp_d) begin
            n_fail++; $display("FAIL bp_data: got %p, required %p", got_rdata, exp_d);
        end
        n_tests++;
        if (st_addr.size() !== 2 || (st_addr.size() == 2 && st_addr[1] !== 32'h82)) begin
            n_fail++; $display("FAIL bp_strobes: got %p, required 80 82", st_addr);
        end
    endtask

    task automatic test_err_capture();
        bit ok;
        clear_env();
        for (int i = 0; i < 4; i++) wq.push_back($urandom);
        resp_err = '{1'b0, 1'b1, 1'b1, 1'b0};
        start_cmd(1'b0, 32'h200, 3'h4, 16'd4);
        wait_done(ok);
        repeat (3) @(negedge tck);
        n_tests++;
        if (err !== 1'b1 || err_addr !== 32'h204) begin
            n_fail++; $display("FAIL err_capture: err=%b addr=%h, required 1 204", err, err_addr);
        end
        n_tests++;
        if (st_addr.size() !== 4 || words_done !== 16'd4) begin
            n_fail++;
            $display("FAIL err_words: strobes=%0d words=%0d, required 4 4", st_addr.size(), words_done);
        end
    endtask

    task automatic test_abort();
        bit ok;
        bit seen;
        int d0;
        logic [31:0] exp_d[$];
        clear_env();
        for (int i = 0; i < 8; i++) exp_d.push_back($urandom);
        resp_data = exp_d;
        d0 = done_cnt;
        start_cmd(1'b1, 32'h4000, 3'h4, 16'd8);
        n_tests++;
        if (err !== 1'b0 || err_addr !== 32'd0) begin
            n_fail++; $display("FAIL err_cleared: err=%b addr=%h, required 0 0", err, err_addr);
        end
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge tck);
            if (biu_strobe) seen = 1'b1;
        end
        @(posedge tck); #1;
        abort = 1'b1;
        @(posedge tck); #1;
        abort = 1'b0;
        wait_done(ok);
        repeat (6) @(negedge tck);
        n_tests++;
        if (got_rdata.size() !== 1 || (got_rdata.size() == 1 && got_rdata[0] !== exp_d[0])) begin
            n_fail++; $display("FAIL abort_data: got %p, required %h only", got_rdata, exp_d[0]);
        end
        n_tests++;
        if (!seen || st_addr.size() !== 1 || words_done !== 16'd1 || done_cnt - d0 !== 1) begin
            n_fail++;
            $display("FAIL abort_status: strobes=%0d words=%0d done=%0d, required 1 1 1",
                     st_addr.size(), words_done, done_cnt - d0);
        end
    endtask

    task automatic test_count_zero();
        clear_env();
        start_cmd(1'b1, 32'h10, 3'h4, 16'd0);
        @(negedge tck);
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL zero_done: done=%b busy=%b, required 1 1", done, busy);
        end
        @(negedge tck);
        n_tests++;
        if (done !== 1'b0 || cmd_ready !== 1'b1 || st_addr.size() !== 0 || words_done !== '0) begin
            n_fail++;
            $display("FAIL zero_after: done=%b ready=%b strobes=%0d words=%0d, required 0 1 0 0",
                     done, cmd_ready, st_addr.size(), words_done);
        end
    endtask

    task automatic test_addr_wrap();
        bit ok;
        clear_env();
        start_cmd(1'b1, 32'hFFFF_FFFC, 3'h4, 16'd2);
        wait_done(ok);
        @(negedge tck);
        n_tests++;
        if (st_addr.size() !== 2 || (st_addr.size() == 2 &&
            (st_addr[0] !== 32'hFFFF_FFFC || st_addr[1] !== 32'h0))) begin
            n_fail++; $display("FAIL addr_wrap: got %p, required fffffffc 00000000", st_addr);
        end
    endtask

    task automatic test_random_back_to_back();
        bit          ok, rd;
        logic [31:0] a, exp_a, exp_ea;
        logic [2:0]  sz;
        int          cnt, eff, first_err, d0;
        logic [31:0] dat[$];
        bit          errs[$];
        for (int t = 0; t < 12; t++) begin
            rd = 1'($urandom_range(0, 1));
            a = $urandom;
            sz = 3'($urandom_range(0, 7));
            cnt = $urandom_range(1, 6);
            eff = (sz == 3'h1) ? 1 : (sz == 3'h2) ? 2 : 4;
            dat.delete(); errs.delete();
            first_err = -1;
            for (int i = 0; i < cnt; i++) begin
                dat.push_back($urandom);
                errs.push_back($urandom_range(0, 3) == 0);
                if (errs[i] && first_err < 0) first_err = i;
            end
            clear_env();
            resp_err = errs;
            if (rd) resp_data = dat;
            else wq = dat;
            wr_throttle = 1'($urandom_range(0, 1));
            d0 = done_cnt;
            start_cmd(rd, a, sz, CNT_W'(cnt));
            wait_done(ok);
            @(negedge tck); @(negedge tck);
            n_tests++;
            if (st_addr.size() !== cnt) begin
                n_fail++; $display("FAIL rnd%0d_strobes: got %0d, required %0d", t, st_addr.size(), cnt);
            end
            for (int i = 0; i < cnt && i < st_addr.size(); i++) begin
                exp_a = a + 32'(i * eff);
                n_tests++;
                if (st_addr[i] !== exp_a || st_size[i] !== 3'(eff) || st_rd[i] !== rd ||
                    (!rd && st_data[i] !== dat[i])) begin
                    n_fail++;
                    $display("FAIL rnd%0d_access%0d: addr=%h size=%h rd=%b data=%h, required %h %0d %b %h",
                             t, i, st_addr[i], st_size[i], st_rd[i], st_data[i], exp_a, eff, rd, dat[i]);
                end
            end
            if (rd) begin
                n_tests++;
                if (got_rdata !== dat) begin
                    n_fail++; $display("FAIL rnd%0d_rdata: got %p, required %p", t, got_rdata, dat);
                end
            end
            exp_ea = (first_err >= 0) ? a + 32'(first_err * eff) : 32'd0;
            n_tests++;
            if (err !== (first_err >= 0) || err_addr !== exp_ea) begin
                n_fail++;
                $display("FAIL rnd%0d_err: err=%b addr=%h, required %b %h", t, err, err_addr, first_err >= 0, exp_ea);
            end
            n_tests++;
            if (words_done !== CNT_W'(cnt) || done_cnt - d0 !== 1) begin
                n_fail++;
                $display("FAIL rnd%0d_done: words=%0d done=%0d, required %0d 1", t, words_done, done_cnt - d0, cnt);
            end
        end
        wr_throttle = 1'b0;
        n_tests++;
        if (viol_cnt !== 0) begin
            n_fail++; $display("FAIL rnd_strobe_rdy: strobes without rdy=%0d, required 0", viol_cnt);
        end
    endtask

    task automatic test_reset_mid_burst();
        clear_env();
        start_cmd(1'b0, 32'h40, 3'h2, 16'd5);
        repeat (3) @(negedge tck);
        n_tests++;
        if (busy !== 1'b1 || wdata_ready !== 1'b1 || biu_addr !== 32'h40 || biu_rd_wrn !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_pre: busy=%b wready=%b addr=%h rd=%b, required 1 1 40 0",
                     busy, wdata_ready, biu_addr, biu_rd_wrn);
        end
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || wdata_ready !== 1'b0 || biu_addr !== 32'd0 ||
            biu_size !== 3'h4 || biu_rd_wrn !== 1'b1 || words_done !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: busy=%b ready=%b wready=%b addr=%h size=%h rd=%b words=%0d, required 0 1 0 0 4 1 0",
                     busy, cmd_ready, wdata_ready, biu_addr, biu_size, biu_rd_wrn, words_done);
        end
        @(posedge tck); #1;
        rst = 1'b0;
        @(negedge tck);
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_throttled();
        test_read_backpressure();
        test_err_capture();
        test_abort();
        test_count_zero();
        test_addr_wrap();
        test_random_back_to_back();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adbg_wb_burst_ctrl.md
Name: adbg_wb_burst_ctrl

Overview:
Burst sequencer sitting between a debug-module command decoder and the WishBone BIU's TCK-side strobe/ready interface.
- Accepts one burst command: start address, word size, word count, direction.
- Issues one BIU access per word, stepping the address by the word size.
- Moves write data in and read data out through valid/ready handshakes.
- Reports completion, a sticky error and the address of the first failing word.
- Runs entirely in the TCK domain; the BIU handles the WishBone clock crossing.

Parameters:
CNT_W, 16, width of the word-count field and of the words-done counter.

Ports:
tck_i  in  1  clock (TCK domain)
rst_i  in  1  reset; asynchronous, active-high
cmd_valid_i  in  1  burst command valid
cmd_ready_o  out  1  command accepted when high together with cmd_valid_i
cmd_rd_wrn_i  in  1  1 = read burst, 0 = write burst
cmd_addr_i  in  32  start byte address
cmd_size_i  in  3  word size in bytes: 1, 2 or 4
cmd_count_i  in  CNT_W  number of words in the burst
abort_i  in  1  request to stop after the current word
wdata_i  in  32  write word; short words in upper bits
wdata_valid_i  in  1  write word valid
wdata_ready_o  out  1  write word accepted
rdata_o  out  32  read word as returned by the BIU
rdata_valid_o  out  1  read word valid
rdata_ready_i  in  1  read word consumed
busy_o  out  1  burst in progress
done_o  out  1  one-cycle pulse at burst end
err_o  out  1  sticky: at least one word of the last burst errored
err_addr_o  out  32  address of the first errored word
words_done_o  out  CNT_W  words completed in the current or last burst
biu_strobe_o  out  1  to BIU strobe_i
biu_rd_wrn_o  out  1  to BIU rd_wrn_i
biu_addr_o  out  32  to BIU addr_i
biu_data_o  out  32  to BIU data_i
biu_size_o  out  3  to BIU word_size_i
biu_rdy_i  in  1  from BIU rdy_o
biu_err_i  in  1  from BIU err_o
biu_data_i  in  32  from BIU data_o

Behaviour:
- Reset values:
  - cmd_ready_o=1; wdata_ready_o=0; rdata_valid_o=0; busy_o=0; done_o=0; err_o=0.
  - err_addr_o=0; words_done_o=0; rdata_o=0.
  - biu_strobe_o=0; biu_rd_wrn_o=1; biu_addr_o=0; biu_data_o=0; biu_size_o=3'h4.
  - FSM resets to IDLE.
- States: IDLE, FETCH, ISSUE, WAIT, DELIVER, DONE.
- IDLE:
  - cmd_ready_o=1, busy_o=0.
  - On cmd_valid_i: latch addr, size, count and direction into the biu_* registers and the remaining counter.
  - Clear err_o, err_addr_o, words_done_o and the abort latch.
  - Next state: count=0 -> DONE (no BIU access); write -> FETCH; read -> ISSUE.
- Size: legal values are 3'h1, 3'h2 and 3'h4. Any other value is stored as 3'h4 and treated as 4.
- FETCH (write only):
  - wdata_ready_o=1.
  - On wdata_valid_i: latch wdata_i into biu_data_o, then go to ISSUE.
- ISSUE:
  - biu_strobe_o = biu_rdy_i (combinational, exactly one cycle high).
  - Stay in ISSUE until biu_rdy_i=1; go to WAIT in the strobe cycle.
- WAIT:
  - biu_rdy_i is ignored in the first WAIT cycle, because the BIU drops rdy one cycle after the strobe.
  - From the second cycle on, wait for biu_rdy_i=1. In that cycle:
    - If biu_err_i=1 and err_o=0: set err_o and load err_addr_o with the current biu_addr_o.
    - Increment words_done_o.
    - Read: load rdata_o from biu_data_i, set rdata_valid_o, go to DELIVER.
    - Write: advance (rule below).
- DELIVER:
  - Hold rdata_o and rdata_valid_o until rdata_ready_i=1.
  - On the handshake: clear rdata_valid_o and advance.
  - No new BIU access is issued while a read word is unconsumed.
- Advance:
  - biu_addr_o += size, modulo 2^32 (wraps 0xFFFFFFFC -> 0x00000000).
  - remaining -= 1.
  - If remaining reaches 0 or the abort latch is set -> DONE. Otherwise write -> FETCH, read -> ISSUE.
- DONE: done_o=1 for one cycle, then IDLE. busy_o=1 in every state except IDLE.
- abort_i:
  - Sampled in any non-IDLE state and sets the abort latch.
  - The in-flight BIU access always completes; an outstanding read word is still delivered.
  - In FETCH, abort goes directly to DONE without a BIU access.
- Errors do not stop the burst. err_o and err_addr_o keep the first error until the next command is accepted.
- biu_addr_o, biu_size_o, biu_rd_wrn_o and biu_data_o are registered and stable from the strobe cycle until rdy returns.
- Asynchronous reset mid-burst returns every output to its reset value immediately. A BIU transaction already in flight is the BIU's concern; the BIU is reset on the same rst_i.

Test Plan:
1. Read burst, addr 0x1000, size 4, count 3, BIU returning 0xA, 0xB, 0xC -> strobes at addr 0x1000, 0x1004, 0x1008; rdata_o sequence 0xA, 0xB, 0xC; done_o pulses once; words_done_o=3; err_o=0.
2. Write burst, size 1, count 4, addr 0x3, wdata_valid_i throttled every other cycle -> biu_addr_o 0x3, 0x4, 0x5, 0x6; one strobe per accepted word; no strobe while biu_rdy_i=0.
3. Read count 2, rdata_ready_i held low 10 cycles after word 1 -> no second strobe until word 1 is consumed; then the burst completes normally.
4. biu_err_i=1 on words 2 and 3 of a 4-word write at addr 0x200 -> err_o=1, err_addr_o=0x204, all 4 words issued, words_done_o=4.
5. abort_i pulsed during WAIT of word 1 of a count-8 read -> word 1 delivered, done_o pulses, words_done_o=1, no second strobe.
6. count=0 command -> done_o one cycle after acceptance, no strobe. Separately: addr 0xFFFFFFFC, size 4, count 2 -> second address 0x00000000.
